// File: rtl/bcd_serial_adder.sv
// ============================================================================
// bcd_serial_adder
//
// Multi-digit packed-BCD adder/subtractor that resolves one decimal digit per
// clock, least-significant digit first. A single digit slice (binary add plus
// decimal correction) is reused DIGITS times, trading latency for area.
//
// Parameters
//   DIGITS  number of packed BCD digits per operand (1..16)
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   START  in   begin an operation (only taken while BUSY=0)
//   A, B   in   packed BCD operands, digit 0 in bits [3:0]
//   CIN    in   carry-in (add) / borrow-in (subtract)
//   SUB    in   1 selects A-B-CIN (only when BCD_SUB_EN is defined)
//   BUSY   out  operation in progress
//   DONE   out  one-cycle pulse, result valid from this cycle on
//   SUM    out  packed BCD result, held until the next completion
//   COUT   out  decimal carry-out (add) / borrow-out (subtract)
//   ERR    out  a latched operand digit was greater than 9
//
// Build option
//   BCD_SUB_EN  when defined, SUB enables ten's-complement subtraction.
//               When undefined, SUB is accepted but ignored (add-only) and no
//               complement logic exists. Port list is the same in both builds.
// ============================================================================
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    input  logic                CIN,
    input  logic                SUB,
    output logic                BUSY,
    output logic                DONE,
    output logic [4*DIGITS-1:0] SUM,
    output logic                COUT,
    output logic                ERR
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    // Handshake: START is a request, BUSY=0 is the ready. A request is taken
    // on any rising edge where START=1 and BUSY=0 (IDLE or FIN). While BUSY=1
    // START and all operand inputs are ignored. DONE pulses for exactly one
    // cycle when SUM/COUT/ERR update; they then hold until the next DONE.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  work_q;
    logic [W-1:0]  work_d;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          err_pend_q;

    logic          accept;
    logic          last_digit;
    logic [CW+1:0] bit_base;
    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    b_eff;
    logic [4:0]    t_sum;
    logic [3:0]    dig_res;
    logic          carry_n;
    logic          carry_init;
    logic          cout_n;

`ifdef BCD_SUB_EN
    logic sub_q;
`else
    // SUB stays on the port list in the add-only build but drives nothing.
    logic unused_sub;
    assign unused_sub = SUB;
`endif

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign accept     = START && (state_q != S_CALC);
    assign last_digit = (cnt_q == CW'(DIGITS - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (last_digit) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = START ? S_CALC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_CALC:  BUSY = 1'b1;
            S_FIN:   DONE = 1'b1;
            default: begin
                BUSY = 1'b0;
                DONE = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Digit slice: one decimal digit of A + B' + carry with decimal correction
    // ------------------------------------------------------------------------
    always_comb begin
        bit_base = {cnt_q, 2'b00};
        a_dig    = a_q[bit_base +: 4];
        b_dig    = b_q[bit_base +: 4];
`ifdef BCD_SUB_EN
        // 9's complement of the subtrahend digit; wraps mod 16 for bad digits.
        b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
`else
        b_eff    = b_dig;
`endif
        t_sum    = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        if (t_sum > 5'd9) begin
            // Adding 6 skips the six unused codes; only the low nibble is kept.
            dig_res = t_sum[3:0] + 4'd6;
            carry_n = 1'b1;
        end else begin
            dig_res = t_sum[3:0];
            carry_n = 1'b0;
        end
        work_d               = work_q;
        work_d[bit_base +: 4] = dig_res;
`ifdef BCD_SUB_EN
        // In ten's-complement subtraction a final carry means "no borrow".
        carry_init = SUB ? ~CIN : CIN;
        cout_n     = sub_q ? ~carry_n : carry_n;
`else
        carry_init = CIN;
        cout_n     = carry_n;
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            err_pend_q <= 1'b0;
            SUM        <= '0;
            COUT       <= 1'b0;
            ERR        <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q      <= 1'b0;
`endif
        end else if (accept) begin
            a_q        <= A;
            b_q        <= B;
            work_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= carry_init;
            err_pend_q <= has_bad_digit(A) | has_bad_digit(B);
`ifdef BCD_SUB_EN
            sub_q      <= SUB;
`endif
        end else if (state_q == S_CALC) begin
            work_q  <= work_d;
            carry_q <= carry_n;
            cnt_q   <= cnt_q + CW'(1);
            // The last digit is folded in directly so SUM only ever sees a
            // complete result, on the same edge that enters FIN.
            if (last_digit) begin
                SUM  <= work_d;
                COUT <= cout_n;
                ERR  <= err_pend_q;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
// tb_bcd_serial_adder
//
// Self-checking bench for bcd_serial_adder (DIGITS=4). Directed operations
// from the test plan plus randomized operations are compared against a
// decimal-arithmetic reference model through a scoreboard queue.
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         SUB;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         ERR;

    // {cout, err, sum}
    logic [W+1:0] exp_q[$];

    int n_checks;
    int n_pass;
    int n_fail;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .SUB   (SUB),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT),
        .ERR   (ERR)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic any_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic longint to_int(input logic [W-1:0] v);
        longint r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] s;
        longint       r;
        r = v;
        s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return s;
    endfunction

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic         do_sub;
        logic         err;
        logic         cout;
        logic         c;
        logic [W-1:0] s;
        logic [3:0]   ad;
        logic [3:0]   bd;
        longint       p;
        longint       r;
        int           t;
        do_sub = SUB_EN && sub;
        err    = any_bad(a) | any_bad(b);
        s      = '0;
        if (!err) begin
            p = 1;
            for (int i = 0; i < DIGITS; i++) p = p * 10;
            if (do_sub) begin
                r    = to_int(a) - to_int(b) - longint'(cin);
                cout = (r < 0);
                if (r < 0) r = r + p;
            end else begin
                r    = to_int(a) + to_int(b) + longint'(cin);
                cout = (r >= p);
                if (cout) r = r - p;
            end
            s = to_bcd(r);
        end else begin
            // Out-of-range digits: apply the per-digit arithmetic rule literally.
            c = do_sub ? ~cin : cin;
            for (int i = 0; i < DIGITS; i++) begin
                ad = a[4*i +: 4];
                bd = b[4*i +: 4];
                if (do_sub) bd = 4'(9 - int'(bd));
                t = int'(ad) + int'(bd) + int'(c);
                if (t > 9) begin
                    s[4*i +: 4] = 4'(t + 6);
                    c = 1'b1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 1'b0;
                end
            end
            cout = do_sub ? ~c : c;
        end
        return {cout, err, s};
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'($urandom_range(0, 9));
            if (allow_bad && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // ---------------- driver tasks (entered and left at a falling edge) ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input bit hold, input bit scramble);
        logic [W+1:0] exp;
        A     = a;
        B     = b;
        CIN   = cin;
        SUB   = sub;
        START = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
        for (int c = 1; c <= DIGITS; c++) begin
            @(negedge CLK);
            check("busy", 32'(BUSY), 32'd1);
            check("done_early", 32'(DONE), 32'd0);
            if (!hold) START = 1'b0;
            if (scramble) begin
                A   = W'($urandom);
                B   = W'($urandom);
                CIN = 1'($urandom_range(0, 1));
                SUB = 1'($urandom_range(0, 1));
            end
        end
        @(negedge CLK);
        START = 1'b0;
        check("done", 32'(DONE), 32'd1);
        check("busy_fin", 32'(BUSY), 32'd0);
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("sum", 32'(SUM), 32'(exp[W-1:0]));
            check("err", 32'(ERR), 32'(exp[W]));
            check("cout", 32'(COUT), 32'(exp[W+1]));
        end
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            check("idle_done", 32'(DONE), 32'd0);
            check("idle_busy", 32'(BUSY), 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        RST_N    = 1'b0;
        START    = 1'b0;
        A        = '0;
        B        = '0;
        CIN      = 1'b0;
        SUB      = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_sum", 32'(SUM), 32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        RST_N = 1'b1;
        idle(2);

        // Directed cases from the test plan
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_op(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_op(16'h0005, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // START held through BUSY, operands scrambled mid-operation
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Back-to-back: second START given during the DONE cycle
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset during CALC cycle 2: outputs cleared at once, no DONE
        A     = 16'h2222;
        B     = 16'h3333;
        CIN   = 1'b0;
        SUB   = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_done", 32'(DONE), 32'd0);
        check("mid_rst_sum", 32'(SUM), 32'd0);
        check("mid_rst_cout", 32'(COUT), 32'd0);
        check("mid_rst_err", 32'(ERR), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(DIGITS + 2);
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Randomized operations with occasional bad digits, holds and gaps
        for (int n = 0; n < 40; n++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
